// File: rtl/nand_target_pkg.sv
// nand_target_pkg: opcodes, states, cycle types and status layout for the NAND target responder
package nand_target_pkg;
  localparam logic [7:0] OP_READ1 = 8'h00, OP_READ2 = 8'h30, OP_STATUS = 8'h70, OP_PROG1 = 8'h80;
  localparam logic [7:0] OP_PROG2 = 8'h10, OP_ID = 8'h90, OP_RESET = 8'hFF;
  localparam int ST_WP = 7, ST_RDY = 6, ST_ARDY = 5, ST_FAIL = 0;
  typedef enum logic [2:0] {IDLE, ADDR, DIN, WCONF, BUSY, DOUT} state_t;
  typedef enum logic [2:0] {CY_CMD, CY_ADDR, CY_DIN, CY_DOUT, CY_BAD} cycle_t;
  typedef enum logic [1:0] {K_READ, K_PROG, K_ID, K_RST} kind_t;
  function automatic logic [7:0] status_byte(input logic wp_n, input logic rdy, input logic fail);
    logic [7:0] s;
    s = 8'h00;
    s[ST_WP] = wp_n;
    s[ST_RDY] = rdy;
    s[ST_ARDY] = rdy;
    s[ST_FAIL] = fail;
    return s;
  endfunction
endpackage

// File: rtl/nand_strobe_sync.sv
// nand_strobe_sync: two-flop synchronizers and nand_clk rising-edge strobe with cycle classification
module nand_strobe_sync
  import nand_target_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       nand_clk,
  input  logic       wr,
  input  logic       ale,
  input  logic       cle,
  input  logic       ce_n,
  input  logic       wp_n,
  input  logic [7:0] dq_in,
  output logic       strobe,
  output logic [2:0] cycle,
  output logic [7:0] dq,
  output logic       rd_en,
  output logic       wp
);
  // bit map of each stage: [13] nand_clk, [12] wr, [11] ale, [10] cle, [9] ce_n, [8] wp_n, [7:0] dq
  logic [13:0] s1, s2;
  logic nclk_d;
  always_ff @(posedge clk)
    if (rst) {s1, s2, nclk_d} <= '0;
    else {s1, s2, nclk_d} <= {{nand_clk, wr, ale, cle, ce_n, wp_n, dq_in}, s1, s2[13]};
  assign strobe = s2[13] & ~nclk_d & ~s2[9];
  assign rd_en = ~s2[12] & ~s2[9];
  assign wp = s2[8];
  assign dq = s2[7:0];
  always_comb
    cycle = !s2[12] ? ((s2[11] | s2[10]) ? CY_BAD : CY_DOUT)
          : (s2[10] & !s2[11]) ? CY_CMD
          : (s2[11] & !s2[10]) ? CY_ADDR
          : (!s2[10] & !s2[11]) ? CY_DIN : CY_BAD;
endmodule

// File: rtl/nand_target_responder.sv
// nand_target_responder: device-side NAND target with paged array, busy windows, ID and status
module nand_target_responder
  import nand_target_pkg::*;
#(
  parameter int PAGE_BYTES = 16,
  parameter int NUM_PAGES = 4,
  parameter int T_READ = 50,
  parameter int T_PROG = 200,
  parameter int T_RST = 20,
  parameter logic [31:0] ID_WORD = 32'h2CDA9095
) (
  input  logic       clock_100,
  input  logic       rst,
  input  logic       nand_clk,
  input  logic       wr,
  input  logic       ale,
  input  logic       cle,
  input  logic       ce_n,
  input  logic       wp_n,
  input  logic [7:0] dq_in,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  output logic       rb,
  output logic       cmd_err
);
  localparam int CW = $clog2(PAGE_BYTES), RW = $clog2(NUM_PAGES);
  logic strobe, rd_en, wp, is_cmd, copy, acnt, fail, status_mode;
  logic [2:0] cycle;
  logic [7:0] dq, status;
  state_t state;
  kind_t kind;
  logic [CW-1:0] col, nxt, cidx;
  logic [RW-1:0] row;
  logic [15:0] cnt;
  logic [7:0] pbuf [PAGE_BYTES];
  logic [7:0] mem [NUM_PAGES*PAGE_BYTES];
  function automatic logic [7:0] id_byte(input logic [1:0] i);
    return ID_WORD[8*(3-int'(i)) +: 8];
  endfunction
  nand_strobe_sync sync (
    .clk(clock_100), .rst(rst), .nand_clk(nand_clk), .wr(wr), .ale(ale), .cle(cle),
    .ce_n(ce_n), .wp_n(wp_n), .dq_in(dq_in), .strobe(strobe), .cycle(cycle), .dq(dq),
    .rd_en(rd_en), .wp(wp)
  );
  assign nxt = col + 1'b1;
  assign cidx = CW'(PAGE_BYTES - int'(cnt));
  assign copy = state == BUSY && cnt != 16'd0 && cnt <= 16'(PAGE_BYTES);
  assign status = status_byte(wp, rb, fail);
  assign is_cmd = strobe && cycle == CY_CMD;
  // the last PAGE_BYTES busy cycles move one byte per cycle between array and page buffer
  always_ff @(posedge clock_100) begin
    if (!rst && copy && kind == K_READ) pbuf[cidx] <= mem[{row, cidx}];
    if (!rst && strobe && cycle == CY_DIN && state == DIN) pbuf[col] <= dq;
    if (!rst && copy && kind == K_PROG) mem[{row, cidx}] <= pbuf[cidx];
  end
  always_ff @(posedge clock_100)
    if (rst) begin
      state <= IDLE;
      kind <= K_READ;
      col <= '0;
      row <= '0;
      cnt <= '0;
      acnt <= 1'b0;
      fail <= 1'b0;
      status_mode <= 1'b0;
      rb <= 1'b1;
      dq_oe <= 1'b0;
      dq_out <= 8'h00;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      dq_oe <= rd_en && (state == DOUT || status_mode);
      if (state == BUSY) begin
        if (cnt == 16'd1) begin
          rb <= 1'b1;
          state <= kind == K_READ ? DOUT : IDLE;
          if (kind == K_READ) dq_out <= mem[{row, col}];
        end
        cnt <= cnt - 16'd1;
      end
      if (strobe)
        case (cycle)
          CY_CMD:
            if (dq == OP_RESET) begin
              state <= BUSY;
              kind <= K_RST;
              cnt <= 16'(T_RST);
              rb <= 1'b0;
              fail <= 1'b0;
              status_mode <= 1'b0;
            end else if (dq == OP_STATUS) status_mode <= 1'b1;
            else if (state == BUSY) cmd_err <= 1'b1;
            else begin
              status_mode <= 1'b0;
              acnt <= 1'b0;
              if (state == WCONF && dq == OP_READ2) begin
                state <= BUSY;
                cnt <= 16'(T_READ);
                rb <= 1'b0;
              end else if (state == DIN && dq == OP_PROG2) begin
                if (wp) begin
                  state <= BUSY;
                  kind <= K_PROG;
                  cnt <= 16'(T_PROG);
                  rb <= 1'b0;
                end else begin
                  fail <= 1'b1;
                  state <= IDLE;
                end
              end else begin
                // a pending read confirm that sees another opcode flags it, then starts over
                cmd_err <= state == WCONF || !(dq inside {OP_READ1, OP_PROG1, OP_ID});
                state <= dq inside {OP_READ1, OP_PROG1, OP_ID} ? ADDR : IDLE;
                kind <= dq == OP_PROG1 ? K_PROG : dq == OP_ID ? K_ID : K_READ;
                if (dq == OP_PROG1) fail <= 1'b0;
              end
            end
          CY_ADDR:
            if (state != ADDR) cmd_err <= 1'b1;
            else if (kind == K_ID) begin
              col <= '0;
              state <= DOUT;
              dq_out <= id_byte(2'd0);
            end else if (!acnt) begin
              col <= dq[CW-1:0];
              acnt <= 1'b1;
            end else begin
              row <= dq[RW-1:0];
              state <= kind == K_READ ? WCONF : DIN;
            end
          CY_DIN:
            if (state == DIN) col <= nxt;
            else cmd_err <= 1'b1;
          CY_DOUT:
            if (!status_mode) begin
              if (state == DOUT) begin
                col <= nxt;
                dq_out <= kind == K_ID ? id_byte(nxt[1:0]) : pbuf[nxt];
              end else cmd_err <= 1'b1;
            end
          default: cmd_err <= 1'b1;
        endcase
      if (status_mode || (is_cmd && dq == OP_STATUS)) dq_out <= status;
    end
endmodule

// File: tb/tb_nand_target_responder.sv
// tb_nand_target_responder: directed host sequences checked against a page/buffer model of the target
module tb_nand_target_responder;
  localparam int PB = 16, NP = 4;
  localparam logic [31:0] IDW = 32'h2CDA9095;
  logic clock_100 = 0, rst = 1, nand_clk = 0, wr = 1, ale = 0, cle = 0, ce_n = 0, wp_n = 1;
  logic [7:0] dq_in = 8'h00, dq_out;
  logic dq_oe, rb, cmd_err;
  int compared = 0, mismatched = 0, errs = 0, exp_errs = 0;
  int lo = 0, last_lo = 0, npulse = 0, cyc_n = 0, rise_at = 0;
  int mem_m [NP*PB];
  int buf_m [PB];
  int m_col = 0, m_row = 0;
  bit m_fail = 0;

  nand_target_responder dut (
    .clock_100(clock_100), .rst(rst), .nand_clk(nand_clk), .wr(wr), .ale(ale), .cle(cle),
    .ce_n(ce_n), .wp_n(wp_n), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .rb(rb),
    .cmd_err(cmd_err)
  );

  always #5 clock_100 = ~clock_100;
  always @(posedge clock_100) cyc_n++;
  // cmd_err pulses and completed rb-low widths, sampled mid-cycle
  always @(negedge clock_100) begin
    if (cmd_err) errs++;
    if (!rb) lo++;
    else if (lo != 0) begin
      last_lo = lo;
      npulse++;
      lo = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int st(input bit rdy);
    return {24'd0, wp_n, rdy, rdy, 4'b0, m_fail};
  endfunction

  task automatic bus(input logic w, input logic c, input logic a, input logic [7:0] d);
    @(posedge clock_100); #1;
    wr = w; cle = c; ale = a; dq_in = d; nand_clk = 0;
    repeat (4) @(posedge clock_100);
    #1 nand_clk = 1;
    rise_at = cyc_n;
    repeat (5) @(posedge clock_100);
    #1 nand_clk = 0;
  endtask

  task automatic cmd(input logic [7:0] op);
    bus(1, 1, 0, op);
  endtask

  task automatic addr(input logic [7:0] a);
    bus(1, 0, 1, a);
  endtask

  task automatic din(input logic [7:0] d);
    bus(1, 0, 0, d);
    buf_m[m_col] = d;
    m_col = (m_col + 1) % PB;
  endtask

  // host read: sample the presented byte, then strobe to advance
  task automatic rd(input string name, input int exp, input bit oe);
    @(posedge clock_100); #1;
    wr = 0; cle = 0; ale = 0; nand_clk = 0;
    repeat (4) @(posedge clock_100);
    #1;
    check({name, " oe"}, dq_oe, oe);
    if (exp >= 0) check(name, dq_out, exp);
    nand_clk = 1;
    rise_at = cyc_n;
    repeat (5) @(posedge clock_100);
    #1 nand_clk = 0;
  endtask

  task automatic rd_page(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      rd(name, buf_m[m_col], 1);
      m_col = (m_col + 1) % PB;
    end
  endtask

  task automatic wait_rb(input string name);
    int n = 0;
    while (rb !== 1'b1 && n < 2000) begin
      @(posedge clock_100); #1;
      n++;
    end
    check({name, " ready"}, rb, 1);
    @(negedge clock_100); #1;
  endtask

  task automatic start_read(input int col, input int row);
    cmd(8'h00); addr(8'(col)); addr(8'(row)); cmd(8'h30);
    m_col = col;
    m_row = row;
    for (int i = 0; i < PB; i++) buf_m[i] = mem_m[row*PB + i];
  endtask

  task automatic start_prog(input int col, input int row);
    cmd(8'h80);
    m_fail = 0;
    addr(8'(col)); addr(8'(row));
    m_col = col;
    m_row = row;
  endtask

  task automatic commit_prog();
    for (int i = 0; i < PB; i++) mem_m[m_row*PB + i] = buf_m[i];
  endtask

  initial begin
    int t0, t1, np0;
    foreach (mem_m[i]) mem_m[i] = -1;
    foreach (buf_m[i]) buf_m[i] = -1;
    repeat (2) @(posedge clock_100);
    #1 rst = 0;
    check("reset rb", rb, 1);
    check("reset oe", dq_oe, 0);
    check("reset dq", dq_out, 8'h00);
    check("reset err", errs, 0);

    rd("idle read", -1, 0);
    exp_errs++;
    check("idle read err", errs, exp_errs);
    ce_n = 1;
    bus(1, 1, 1, 8'h00);
    ce_n = 0;
    check("ce_n ignored", errs, exp_errs);
    bus(1, 1, 1, 8'h00);
    exp_errs++;
    check("illegal ctl err", errs, exp_errs);
    cmd(8'h70);
    rd("reset status", st(1), 1);
    check("reset status literal", dq_out, 8'hE0);

    cmd(8'h90); addr(8'h00);
    for (int i = 0; i < 5; i++) rd("id byte", int'(IDW[8*(3-i%4) +: 8]), 1);
    addr(8'h00);
    exp_errs++;
    check("extra addr err", errs, exp_errs);

    start_prog(3, 2);
    din(8'hA5); din(8'h5A); din(8'h3C);
    cmd(8'h10);
    commit_prog();
    repeat (10) @(posedge clock_100);
    cmd(8'h70);
    rd("busy status", st(0), 1);
    check("busy status literal", dq_out, 8'h80);
    cmd(8'h00);
    exp_errs++;
    check("cmd in busy err", errs, exp_errs);
    wait_rb("prog");
    check("prog busy width", last_lo, 200);
    rd("ready status", st(1), 1);
    check("ready status literal", dq_out, 8'hE0);

    start_read(3, 2);
    wait_rb("read");
    check("read busy width", last_lo, 50);
    rd("read p2", 8'hA5, 1);
    rd("read p2", 8'h5A, 1);
    rd("read p2", 8'h3C, 1);

    start_prog(0, 1);
    din(8'hB1); din(8'hB2); din(8'hB3);
    cmd(8'h10);
    commit_prog();
    wait_rb("prog p1");
    wp_n = 0;
    np0 = npulse;
    start_prog(0, 1);
    din(8'h11); din(8'h22);
    cmd(8'h10);
    m_fail = 1;
    check("wp rb stays", rb, 1);
    repeat (20) @(posedge clock_100);
    check("wp no busy pulse", npulse, np0);
    cmd(8'h70);
    rd("wp status", st(1), 1);
    check("wp status literal", dq_out, 8'h61);
    wp_n = 1;
    start_read(0, 1);
    wait_rb("wp readback");
    rd_page("wp readback", 3);

    start_prog(0, 1);
    din(8'hC1); din(8'hC2); din(8'hC3);
    cmd(8'h10);
    t0 = rise_at;
    repeat (2) @(posedge clock_100);
    cmd(8'hFF);
    t1 = rise_at;
    m_fail = 0;
    wait_rb("abort");
    check("abort busy width", last_lo, t1 - t0 + 20);
    cmd(8'h70);
    rd("abort status", st(1), 1);
    check("abort status literal", dq_out, 8'hE0);
    start_read(0, 1);
    wait_rb("abort readback");
    rd_page("abort readback", 3);
    check("total cmd_err", errs, exp_errs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/nand_target_responder.md
Name: nand_target_responder

Overview:
- Synthesizable NAND target (device-side) responder for the level-one flash channel: sits on the far end of the channel pins and answers the controller's command, address and data cycles.
- Decodes CLE/ALE/W-R# cycles, holds a small paged array, drives R/B# busy windows and returns read data, ID and status bytes.
- Used for loopback bring-up of the controller without a physical flash part.

Parameters:
- PAGE_BYTES, 16, bytes per page (power of 2).
- NUM_PAGES, 4, pages in array (power of 2).
- T_READ, 50, busy cycles for page read (must be >= PAGE_BYTES).
- T_PROG, 200, busy cycles for page program (must be >= PAGE_BYTES).
- T_RST, 20, busy cycles after FFh.
- ID_WORD, 32'h2CDA9095, ID bytes, MSB first.

Ports:
- clock_100  in  1  system clock; all logic in this domain.
- rst  in  1  synchronous, active-high reset.
- nand_clk  in  1  controller's NAND clock; asynchronous, sampled.
- wr  in  1  W/R#: 1 = host writes, 0 = host reads.
- ale  in  1  address latch enable.
- cle  in  1  command latch enable.
- ce_n  in  1  chip enable, active low.
- wp_n  in  1  write protect, active low.
- dq_in  in  8  DQ from host.
- dq_out  out  8  DQ to host.
- dq_oe  out  1  DQ drive enable; tri-state resolved at top level.
- rb  out  1  ready/busy: 1 = ready.
- cmd_err  out  1  one-cycle pulse on an illegal or ignored cycle.

Behaviour:
- Sync: all inputs pass through 2 flops. A strobe asserts for one cycle when the synced nand_clk rises; ctl/data are taken from the synced copy in that cycle. Host holds ctl/dq >= 3 clock_100 cycles after the nand_clk rise; nand_clk period >= 8 cycles.
- Strobe with ce_n=1: ignored.
- Strobe classification:
  - wr=1, cle=1, ale=0: command.
  - wr=1, ale=1, cle=0: address.
  - wr=1, cle=0, ale=0: data-in.
  - wr=0, cle=0, ale=0: data-out.
  - Anything else: cmd_err.
- Reset values: rb=1, dq_oe=0, dq_out=00h, fail=0, state IDLE, column/row=0. Array and page buffer are not reset.
- Status byte = {wp_n, rdy, rdy, 4'b0, fail}; rdy = rb.
- States: IDLE, ADDR, DIN, WCONF, BUSY, DOUT.
- 90h: expect 1 address cycle, then DOUT sourcing ID_WORD bytes; the byte index wraps mod 4.
- 00h: ADDR collects 2 cycles.
  - Cycle 1 = column (low log2(PAGE_BYTES) bits).
  - Cycle 2 = row (low log2(NUM_PAGES) bits).
  - Then WCONF. 30h there -> BUSY for T_READ cycles; other commands -> cmd_err, then handled as a new command.
  - The final PAGE_BYTES busy cycles copy array[row] to the buffer, 1 byte/cycle. Then DOUT from the latched column.
- 80h: clears fail, ADDR 2 cycles, then DIN. Each data-in writes buffer[col] and col++ mod PAGE_BYTES; unwritten bytes keep prior contents.
  - 10h with wp_n=1: BUSY T_PROG; the final PAGE_BYTES cycles copy the buffer to array[row]. Program overwrites (no erase semantics).
  - 10h with wp_n=0: no busy, array untouched, fail=1.
- DOUT: dq_oe=1 while wr=0 and ce_n=0 (registered, 1-cycle lag). dq_out is preloaded with the first byte. Each data-out strobe advances the pointer (wrap) and loads the next byte 1 cycle after the strobe.
- 70h: accepted in any state including BUSY; sets status_mode and dq_out=status. Status updates live. Cleared by any other command; read/ID data does not resume.
- FFh: accepted in any state. Aborts, rb=0 for T_RST cycles, returns to IDLE, fail=0. Aborting before the copy window leaves the array unchanged; aborting inside it leaves it partial (unspecified).
- rb timing: rb=0 from the cycle after the confirm/FFh strobe for exactly T_x cycles.
- In BUSY, any command other than 70h/FFh, and any address/data cycle: ignored, cmd_err.
- Extra address cycles beyond the expected count: ignored, cmd_err. Data-in outside DIN and data-out outside DOUT/status_mode: cmd_err, dq_oe stays 0.
- rst mid-operation: immediate return to reset values; rb=1 the next cycle.

Decomposition:
- nand_target_pkg: opcodes (00h, 30h, 70h, 80h, 10h, 90h, FFh), state enum, status bit positions, cycle-type enum.
- Sub-module nand_strobe_sync: 2-flop synchronizers plus rising-edge detect; outputs strobe, cycle type and sampled dq.

Test Plan:
- Reset: rst 2 cycles, then 70h + 1 read -> rb=1, dq_out=E0h, cmd_err=0.
- ID: 90h, addr 00h, 5 reads -> 2Ch, DAh, 90h, 95h, 2Ch (wrap).
- Program then read back:
  - Program: 80h, addr 03h/02h, data A5h/5Ah/3Ch, 10h -> rb low exactly 200 cycles.
  - Read: 00h, 03h/02h, 30h -> rb low 50 cycles; reads A5h, 5Ah, 3Ch.
- Status during busy: 70h at cycle 20 of program -> 80h; after rb rises -> E0h.
- Write protect: wp_n=0, program page 1 -> rb stays 1, status 61h, page 1 readback unchanged.
- Abort: FFh at busy cycle 10 of program -> rb low 20 cycles from FFh, status E0h, page readback = old data.
